// File: rtl/irq_jump_pkg.sv
// Shared types and helpers for the program-flow redirect controller:
// FSM state, priority encoder and interrupt vector computation.
package irq_jump_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        SHADOW = 1'b1
    } state_t;

    localparam int MAX_IRQ = 32;

    typedef struct packed {
        logic       valid;
        logic [5:0] idx;
    } prio_t;

    // Lowest set index wins, matching "channel 0 is highest priority".
    function automatic prio_t prio_enc(input logic [MAX_IRQ-1:0] req);
        prio_t r;
        r.valid = 1'b0;
        r.idx   = '0;
        for (int i = MAX_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                r.valid = 1'b1;
                r.idx   = 6'(i);
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] vec_addr(input logic [31:0] base,
                                             input logic [31:0] stride,
                                             input logic [5:0]  idx);
        return base + stride * {26'd0, idx};
    endfunction

endpackage

// File: rtl/irq_ret_stack.sv
// Return-address LIFO holding {address, interrupted priority level} per entry.
// The controller never requests push and pop in the same cycle.
module irq_ret_stack #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8,
    parameter int LVL_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [LVL_W-1:0]  push_lvl,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W-1:0] top_addr,
    output logic [LVL_W-1:0]  top_lvl
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [LVL_W-1:0]  lvl_mem  [DEPTH];
    logic [CNT_W-1:0]  cnt;
    logic [PTR_W-1:0]  top_ptr;

    assign full     = (cnt == CNT_W'(DEPTH));
    assign empty    = (cnt == '0);
    assign top_ptr  = PTR_W'(cnt - CNT_W'(1));
    assign top_addr = addr_mem[top_ptr];
    assign top_lvl  = lvl_mem[top_ptr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (push && !full) begin
            cnt <= cnt + CNT_W'(1);
        end else if (pop && !empty) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Entry storage carries no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            addr_mem[PTR_W'(cnt)] <= push_addr;
            lvl_mem[PTR_W'(cnt)]  <= push_lvl;
        end
    end

endmodule

// File: rtl/irq_jump_ctrl.sv
// Redirect controller: merges jumps, reti and prioritised nestable interrupts
// into one registered PC override, followed by a wrong-path shadow window.
module irq_jump_ctrl
    import irq_jump_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int NUM_IRQ     = 4,
    parameter int STACK_DEPTH = 4,
    parameter int VEC_BASE    = 8'hF0,
    parameter int VEC_STRIDE  = 4,
    parameter int SHADOW_CYC  = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               jmp_req,
    input  logic               cond_met,
    input  logic [ADDR_W-1:0]  jmp_target,
    input  logic               reti,
    input  logic [ADDR_W-1:0]  current_addr,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [NUM_IRQ-1:0] irq_mask,
    output logic               pc_mux_sel,
    output logic [ADDR_W-1:0]  jmp_loc,
    output logic [NUM_IRQ-1:0] irq_ack,
    output logic               in_isr,
    output logic               stack_full,
    output logic               err_underflow
);

    localparam int LVL_W = $clog2(NUM_IRQ + 1);
    localparam int SH_W  = $clog2(SHADOW_CYC + 2);

    state_t             state;
    logic [SH_W-1:0]    shadow_cnt;
    logic [NUM_IRQ-1:0] irq_prev;
    logic [NUM_IRQ-1:0] pending;
    logic [LVL_W-1:0]   cur_lvl;

    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] elig;
    logic [NUM_IRQ-1:0] acc_onehot;
    prio_t              cand;
    logic [LVL_W-1:0]   cand_lvl;
    logic               take_jmp;
    logic               accept;
    logic               do_pop;
    logic               underflow;
    logic               redir;
    logic [ADDR_W-1:0]  redir_loc;
    logic [ADDR_W-1:0]  ret_addr;
    logic [ADDR_W-1:0]  vec;
    logic               stk_full;
    logic               stk_empty;
    logic [ADDR_W-1:0]  top_addr;
    logic [LVL_W-1:0]   top_lvl;

    always_comb begin
        rise     = irq & ~irq_prev;
        take_jmp = jmp_req & cond_met;
        elig     = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            elig[i] = pending[i] & ~irq_mask[i] & (i < int'(cur_lvl));
        end
        cand       = prio_enc(32'(elig));
        cand_lvl   = LVL_W'(cand.idx);
        acc_onehot = NUM_IRQ'(1) << cand.idx;
        vec        = ADDR_W'(vec_addr(32'(VEC_BASE), 32'(VEC_STRIDE), cand.idx));
        // A coincident taken jump becomes the return point so it is not lost.
        ret_addr   = take_jmp ? jmp_target : current_addr;

        accept    = (state == RUN) && cand.valid && !stk_full;
        do_pop    = (state == RUN) && !accept && reti && !stk_empty;
        underflow = (state == RUN) && !accept && reti && stk_empty;

        redir     = 1'b0;
        redir_loc = jmp_loc;
        if (accept) begin
            redir     = 1'b1;
            redir_loc = vec;
        end else if (do_pop) begin
            redir     = 1'b1;
            redir_loc = top_addr;
        end else if ((state == RUN) && !reti && take_jmp) begin
            redir     = 1'b1;
            redir_loc = jmp_target;
        end
    end

    irq_ret_stack #(
        .DEPTH (STACK_DEPTH),
        .ADDR_W(ADDR_W),
        .LVL_W (LVL_W)
    ) u_stack (
        .clk      (clk),
        .reset    (reset),
        .push     (accept),
        .pop      (do_pop),
        .push_addr(ret_addr),
        .push_lvl (cur_lvl),
        .full     (stk_full),
        .empty    (stk_empty),
        .top_addr (top_addr),
        .top_lvl  (top_lvl)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= RUN;
            shadow_cnt    <= '0;
            irq_prev      <= '0;
            pending       <= '0;
            cur_lvl       <= LVL_W'(NUM_IRQ);
            pc_mux_sel    <= 1'b0;
            jmp_loc       <= '0;
            irq_ack       <= '0;
            err_underflow <= 1'b0;
        end else begin
            irq_prev   <= irq;
            // A fresh edge on the accepted channel is a new event and re-pends it.
            pending    <= (pending & ~(accept ? acc_onehot : '0)) | rise;
            pc_mux_sel <= redir;
            irq_ack    <= accept ? acc_onehot : '0;

            if (state == SHADOW) begin
                shadow_cnt <= shadow_cnt - SH_W'(1);
                if (shadow_cnt <= SH_W'(1)) state <= RUN;
            end else if (redir) begin
                jmp_loc    <= redir_loc;
                shadow_cnt <= SH_W'(SHADOW_CYC);
                state      <= (SHADOW_CYC > 0) ? SHADOW : RUN;
            end

            if (accept) cur_lvl <= cand_lvl;
            else if (do_pop) cur_lvl <= top_lvl;

            if (underflow) err_underflow <= 1'b1;
        end
    end

    assign in_isr     = !stk_empty;
    assign stack_full = stk_full;

endmodule

// File: doc/irq_jump_ctrl.md
# irq_jump_ctrl

Parametrised program-flow redirect controller for the pipelined core. It merges decoded jump requests, return-from-interrupt, and a vectored, prioritised, nestable multi-line interrupt source into a single registered PC-override (`pc_mux_sel`/`jmp_loc`) for the PC/instruction-memory stage. It replaces the single-line, non-nesting jump control with N prioritised interrupt channels and a hardware return-address stack. It also adds a post-redirect shadow window that suppresses wrong-path requests.

## Interface
Parameters:
- `ADDR_W`, 8: PC/address width.
- `NUM_IRQ`, 4: interrupt channels; channel 0 has the highest priority.
- `STACK_DEPTH`, 4: return-stack entries, which is also the maximum nesting depth.
- `VEC_BASE`, 8'hF0: vector of channel 0.
- `VEC_STRIDE`, 4: the vector of channel i is `VEC_BASE + i*VEC_STRIDE`, modulo 2^ADDR_W.
- `SHADOW_CYC`, 2: cycles after any redirect during which requests are ignored.

Ports:
- `clk` in 1: the single clock. All state updates on its rising edge.
- `reset` in 1: synchronous, active-low reset. Sampled on the `clk` rising edge.
- `jmp_req` in 1: decoded jump or branch in the ID stage.
- `cond_met` in 1: branch condition from the execute flags. An unconditional jump drives it to 1.
- `jmp_target` in ADDR_W: jump destination.
- `reti` in 1: return-from-interrupt decoded.
- `current_addr` in ADDR_W: PC of the instruction in ID.
- `irq` in NUM_IRQ: interrupt lines, rising-edge sensitive.
- `irq_mask` in NUM_IRQ: 1 blocks acceptance of that channel. The pending bit is still recorded.
- `pc_mux_sel` out 1: redirect strobe, registered.
- `jmp_loc` out ADDR_W: redirect address, registered.
- `irq_ack` out NUM_IRQ: one-hot pulse on the cycle the channel is accepted.
- `in_isr` out 1: stack non-empty.
- `stack_full` out 1: stack occupancy equals STACK_DEPTH.
- `err_underflow` out 1: sticky. Set by `reti` with an empty stack.

## Operation
- **Edge detect.** `irq_prev` holds the last sampled `irq`. `pending[i]` is set on `irq[i] & ~irq_prev[i]`. It is cleared only on acceptance or reset.
- **Current level.** `cur_lvl` is the priority of the active ISR; it equals NUM_IRQ when idle. The candidate is the lowest index i with `pending[i] & ~irq_mask[i]` and `i < cur_lvl`.
- **States.**
  - RUN: requests are evaluated.
  - SHADOW: counts down SHADOW_CYC cycles, then returns to RUN. All inputs except `irq` edge capture are ignored.
- **Priority in RUN, highest first:**
  - (1) **Interrupt accept.** Requires a candidate and `!stack_full`.
    - Push {return address, `cur_lvl`}.
    - The return address is `jmp_target` if `jmp_req & cond_met`, else `current_addr`. A coincident jump is therefore not lost.
    - Set `jmp_loc` to the vector, set `cur_lvl` to i, clear `pending[i]`, pulse `irq_ack[i]`.
  - (2) **reti.** If the stack is non-empty, pop: `jmp_loc` gets the popped address and `cur_lvl` the popped level. If the stack is empty, set `err_underflow` and do not redirect.
  - (3) **Jump.** `jmp_req & cond_met` sets `jmp_loc` to `jmp_target`.
- **Redirect effects.** Any redirect asserts `pc_mux_sel` for exactly one cycle and enters SHADOW.
- **reti together with an interrupt.** The interrupt is accepted and the `reti` is dropped. It is a wrong-path instruction, refetched after the ISR returns to `current_addr`.
- **Stack full.** The candidate stays pending. It is accepted after a pop lowers occupancy.
- **Nesting.** Only strictly higher priority (lower index) nests. Equal or lower priority waits for `reti`.

## Timing
- **Redirect latency.** Inputs sampled at edge N produce `pc_mux_sel`/`jmp_loc` valid after edge N, for one cycle.
- **Interrupt latency.** An `irq` edge sampled at edge N sets pending at N. The earliest accept is at N+1, with `pc_mux_sel` and `irq_ack` high during N+1..N+2.
- **Shadow window.** Ignores the SHADOW_CYC cycles after the redirect cycle. Evaluation resumes on the (SHADOW_CYC+1)-th edge after the redirect.
- **Reset state** (`reset`=0 at an edge), and when reset is applied mid-operation:
  - `pc_mux_sel`=0, `jmp_loc`=0, `irq_ack`=0.
  - `in_isr`=0, `stack_full`=0, `err_underflow`=0.
  - pending=0, `irq_prev`=0, stack empty, `cur_lvl`=NUM_IRQ, state RUN.
  - Because `irq_prev` resets to 0, a line held high through reset registers one pending edge on the first active cycle.
- **Address arithmetic.** All address arithmetic wraps at ADDR_W bits.

## Structure
- **Shared package** `irq_jump_pkg`:
  - state enum {RUN, SHADOW}.
  - `prio_enc` function (lowest-index set bit plus valid).
  - `vec_addr` function.
- **Sub-module** `irq_ret_stack`: a LIFO of {ADDR_W address, clog2(NUM_IRQ+1) level} entries.
  - Parameters: depth and widths.
  - Provides push/pop, `full`, `empty` and `top`.
  - Push and pop in the same cycle cannot occur by construction; the controller guarantees it.

## Test plan
All scenarios use the default parameters; channel vectors are F0/F4/F8/FC.
- **Plain jump.** `jmp_req`=1, `cond_met`=1, `jmp_target`=8'h3A -> `pc_mux_sel`=1 and `jmp_loc`=3A for one cycle. A `jmp_req` issued in the next 2 cycles is ignored.
- **Interrupt during jump.** `irq[2]` rises with `current_addr`=10. One cycle later, `jmp_req` with target 8'h55 arrives -> `jmp_loc`=F8, `irq_ack`=0100. The pushed return address is 55. A later `reti` gives `jmp_loc`=55 and `in_isr`=0.
- **Nesting.** In the ISR of channel 2, raise `irq[3]` then `irq[0]` -> channel 0 is accepted (`jmp_loc`=F0) and channel 3 stays pending. After two `reti`s, channel 3 is accepted (FC).
- **Stack full.** Raise channels 3, 2, 1, 0 in sequence with SHADOW gaps -> depth reaches 4 and `stack_full`=1. A further channel-0 edge is not re-accepted until after a `reti`.
- **Mask and underflow.** With `irq_mask`=0001 and `irq[0]` rising -> no ack. Clearing the mask -> ack on the next RUN cycle. `reti` with an empty stack -> `err_underflow`=1 and `pc_mux_sel`=0.
- **Reset mid-ISR.** At depth 2, apply `reset`=0 for one edge -> all outputs 0 and the stack empty. An `irq[1]` held high then produces exactly one ack.
